// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-style bus between the fetch port and the higher-priority data port; 1 cycle request->strobe, ack 1 cycle after bus_ack.
// Requesters hold req until their ack pulse; slave wait states and timeouts stretch the strobe, and stall_req is asserted while a request waits.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW/8-1:0] d_sel,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    output logic            bus_cyc,
    output logic            bus_stb,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW/8-1:0] bus_sel,
    output logic [DW-1:0]   bus_wdata,
    input  logic [DW-1:0]   bus_rdata,
    input  logic            bus_ack,
    output logic            err,
    output logic            stall_req
);
    localparam int SW       = DW / 8;
    localparam int CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

    state_t          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            i_ack_q, i_ack_d;
    logic            d_ack_q, d_ack_d;
    logic            err_q, err_d;
    logic            drop_q, drop_d;
    logic [CW-1:0]   tmo_q, tmo_d;

    logic            tmo_hit;
    logic            done;
    logic            drop_now;

    always_comb begin
        tmo_hit   = (TIMEOUT != 0) && cyc_q && !bus_ack && (tmo_q == CW'(TMO_LAST));
        done      = cyc_q && (bus_ack || tmo_hit);
        drop_now  = drop_q || flush;

        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = 1'b0;
        drop_d    = drop_q;
        tmo_d     = (cyc_q && !bus_ack && !tmo_hit && (TIMEOUT != 0)) ? tmo_q + CW'(1) : '0;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                // A port whose ack is still high has not yet dropped its request.
                if (d_req && !d_ack_q) begin
                    state_d = BUSY_D;
                    cyc_d   = 1'b1;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    sel_d   = d_sel;
                    wdata_d = d_wdata;
                end else if (i_req && !i_ack_q) begin
                    state_d = BUSY_I;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = i_addr;
                    sel_d   = '1;
                end
            end
            BUSY_D: begin
                if (!cyc_q) begin
                    state_d = IDLE;
                end else if (done) begin
                    cyc_d     = 1'b0;
                    d_ack_d   = 1'b1;
                    err_d     = tmo_hit;
                    d_rdata_d = (bus_ack && !we_q) ? bus_rdata : '0;
                end
            end
            BUSY_I: begin
                // cyc low here means the completion cycle, where ack is visible.
                if (!cyc_q) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else begin
                    drop_d = drop_now;
                    if (done) begin
                        cyc_d = 1'b0;
                        if (!drop_now) begin
                            i_ack_d   = 1'b1;
                            err_d     = tmo_hit;
                            i_rdata_d = bus_ack ? bus_rdata : '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus_cyc   = cyc_q;
    assign bus_stb   = cyc_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_sel   = sel_q;
    assign bus_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;
    assign stall_req = !rst && ((d_req && !d_ack_q) || (i_req && !i_ack_q && !flush));

endmodule
